mfm_stream_encoder: RTL and testbench

MFM_STREAM_ENCODER -- requirements
Module: mfm_stream_encoder

---
 rtl/enc_pkg.sv | 28 ++
 rtl/flux_word_encode.sv | 44 ++++
 rtl/mfm_stream_encoder.sv | 179 +++++++++++++++++
 tb/tb_mfm_stream_encoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants, state encoding and the MFM cell-pair rule for the flux stream encoder.
package enc_pkg;

  localparam logic        MODE_MFM    = 1'b0;
  localparam logic        MODE_FM     = 1'b1;
  localparam logic [15:0] SYNC_A1_MFM = 16'h4489;
  localparam logic [15:0] SYNC_C2_MFM = 16'h5224;
  localparam logic [7:0]  FM_CLK_DATA = 8'hFF;
  localparam logic [7:0]  MARK_A1     = 8'hA1;
  localparam logic [7:0]  MARK_C2     = 8'hC2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } enc_state_e;

  // {clock cell, data cell} for one MFM bit given the previously written data bit.
  function automatic logic [1:0] mfm_pair(input logic bit_v, input logic prev_v);
    if (bit_v) begin
      return 2'b01;
    end else if (prev_v) begin
      return 2'b00;
    end else begin
      return 2'b10;
    end
  endfunction

endpackage

// File: rtl/flux_word_encode.sv
// Combinational byte-to-cell-word encoder; cell 15 is written first.
module flux_word_encode
  import enc_pkg::*;
#(
  parameter bit FM_ENABLE = 1'b1
) (
  input  logic [7:0]  data_i,
  input  logic        prev_i,
  input  logic        mode_i,
  input  logic        sync_i,
  input  logic [7:0]  fm_clk_i,
  output logic [15:0] word_o
);

  logic       fm_sel;
  logic       chain;
  logic [2:0] idx;

  assign fm_sel = FM_ENABLE && (mode_i == MODE_FM);

  always_comb begin
    word_o = '0;
    chain  = prev_i;
    idx    = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = 3'(7 - k);
      if (fm_sel) begin
        word_o[{idx, 1'b0} +: 2] = {(sync_i ? fm_clk_i[idx] : 1'b1), data_i[idx]};
      end else begin
        word_o[{idx, 1'b0} +: 2] = mfm_pair(data_i[idx], chain);
      end
      chain = data_i[idx];
    end
    // Marks drop a clock cell; only A1 and C2 have a defined MFM mark form.
    if (!fm_sel && sync_i) begin
      if (data_i == MARK_A1) begin
        word_o = SYNC_A1_MFM;
      end else if (data_i == MARK_C2) begin
        word_o = SYNC_C2_MFM;
      end
    end
  end

endmodule

// File: rtl/mfm_stream_encoder.sv
// Byte-stream to flux-cell serializer: holding register, IDLE/RUN FSM, cell divider, 16-bit shifter.
module mfm_stream_encoder
  import enc_pkg::*;
#(
  parameter int unsigned CELL_DIV_W = 8,
  parameter bit          FM_ENABLE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [CELL_DIV_W-1:0] cell_div,
  input  logic [7:0]            in_data,
  input  logic                  in_sync,
  input  logic [7:0]            in_fm_clk,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  cell_strobe,
  output logic                  flux_out,
  output logic                  busy,
  output logic                  underrun
);

  enc_state_e            state_q, state_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [7:0]            hold_data_q, hold_data_d;
  logic                  hold_sync_q, hold_sync_d;
  logic                  hold_mode_q, hold_mode_d;
  logic [7:0]            hold_fmclk_q, hold_fmclk_d;
  logic [15:0]           shift_q, shift_d;
  logic                  last_q, last_d;
  logic [CELL_DIV_W-1:0] cnt_q, cnt_d;
  logic [CELL_DIV_W-1:0] div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic                  zfill_q, zfill_d;
  logic                  underrun_q, underrun_d;

  logic                  hs;
  logic                  load;
  logic                  cell_end;
  logic                  mode_eff;
  logic [CELL_DIV_W-1:0] div_eff;
  logic [15:0]           enc_word;

  assign mode_eff = FM_ENABLE ? hold_mode_q : MODE_MFM;
  assign div_eff  = (cell_div == '0) ? CELL_DIV_W'(1) : cell_div;
  assign cell_end = (cnt_q == div_q - CELL_DIV_W'(1));
  assign hs       = in_valid && !hold_valid_q;

  flux_word_encode #(
    .FM_ENABLE(FM_ENABLE)
  ) u_enc (
    .data_i  (hold_data_q),
    .prev_i  (last_q),
    .mode_i  (mode_eff),
    .sync_i  (hold_sync_q),
    .fm_clk_i(hold_fmclk_q),
    .word_o  (enc_word)
  );

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_sync_d  = hold_sync_q;
    hold_mode_d  = hold_mode_q;
    hold_fmclk_d = hold_fmclk_q;
    shift_d      = shift_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    bit_d        = bit_q;
    zfill_d      = zfill_q;
    underrun_d   = underrun_q;
    load         = 1'b0;

    if (!enable) begin
      underrun_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable && hold_valid_q) begin
          load    = 1'b1;
          state_d = ST_RUN;
          div_d   = div_eff;
          cnt_d   = '0;
          bit_d   = '0;
          zfill_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          shift_d = '0;
          last_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          zfill_d = 1'b0;
        end else if (cell_end) begin
          cnt_d = '0;
          div_d = div_eff;
          // Word boundary, or any cell boundary while filling with zero cells.
          if (zfill_q || (bit_q == 4'd15)) begin
            bit_d = '0;
            if (hold_valid_q) begin
              load    = 1'b1;
              zfill_d = 1'b0;
            end else begin
              zfill_d    = 1'b1;
              underrun_d = 1'b1;
              shift_d    = '0;
              last_d     = 1'b0;
            end
          end else begin
            shift_d = {shift_q[14:0], 1'b0};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CELL_DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      shift_d      = enc_word;
      last_d       = hold_data_q[0];
      hold_valid_d = 1'b0;
    end

    if (hs) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
      hold_sync_d  = in_sync;
      hold_mode_d  = mode;
      hold_fmclk_d = in_fm_clk;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_sync_q  <= 1'b0;
      hold_mode_q  <= MODE_MFM;
      hold_fmclk_q <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      zfill_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_sync_q  <= hold_sync_d;
      hold_mode_q  <= hold_mode_d;
      hold_fmclk_q <= hold_fmclk_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      zfill_q      <= zfill_d;
      underrun_q   <= underrun_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign cell_strobe = busy && (cnt_q == '0);
  assign flux_out    = cell_strobe && shift_q[15];
  assign underrun    = underrun_q;
  assign in_ready    = !hold_valid_q;

endmodule

// File: tb/tb_mfm_stream_encoder.sv
// Scoreboard bench: stimulus queues expected cells, a monitor checks every strobed cell and its spacing.
module tb_mfm_stream_encoder;
  import enc_pkg::*;

  logic       clk = 1'b0;
  logic       reset, enable, mode, in_sync, in_valid;
  logic [7:0] cell_div, in_data, in_fm_clk;
  logic       in_ready, cell_strobe, flux_out, busy, underrun;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  bit   allow_zero = 1'b0;
  int   exp_period = 1;
  int   zcnt = 0;
  int   nstrobe = 0;

  always #5 clk = ~clk;

  mfm_stream_encoder #(
    .CELL_DIV_W(8),
    .FM_ENABLE (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .cell_div   (cell_div),
    .in_data    (in_data),
    .in_sync    (in_sync),
    .in_fm_clk  (in_fm_clk),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cell_strobe(cell_strobe),
    .flux_out   (flux_out),
    .busy       (busy),
    .underrun   (underrun)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    int   since;
    bit   have_prev;
    logic e;
    since     = 0;
    have_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || !busy) begin
        have_prev = 1'b0;
        since     = 0;
      end else begin
        since++;
        if (cell_strobe) begin
          nstrobe++;
          if (have_prev) chk("strobe_gap", 16'(since), 16'(exp_period));
          have_prev = 1'b1;
          since     = 0;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("flux_cell", 16'(flux_out), 16'(e));
          end else if (allow_zero) begin
            zcnt++;
            chk("zero_cell", 16'(flux_out), 16'h0);
          end else begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe actual=1 required=0 at %0t", $time);
          end
        end else begin
          chk("flux_between_strobes", 16'(flux_out), 16'h0);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic s, input logic m,
                      input logic [7:0] fc, input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 16'(in_ready), 16'h1);
    for (int i = 15; i >= 0; i--) exp_q.push_back(w[i]);
    in_data   = d;
    in_sync   = s;
    mode      = m;
    in_fm_clk = fc;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 16'(exp_q.size()), 16'h0);
  endtask

  task automatic end_stream();
    int n;
    int base;
    allow_zero = 1'b1;
    wait_drain();
    base = zcnt;
    n = 0;
    while (zcnt < base + 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("zero_cells_seen", 16'(zcnt >= base + 2), 16'h1);
    chk("underrun_set", 16'(underrun), 16'h1);
    enable = 1'b0;
    @(negedge clk);
    chk("underrun_clear", 16'(underrun), 16'h0);
    chk("busy_after_abort", 16'(busy), 16'h0);
    exp_q.delete();
    allow_zero = 1'b0;
    enable = 1'b1;
  endtask

  initial begin : stim
    int n;
    int base;
    reset = 1'b1; enable = 1'b0; mode = MODE_MFM; in_sync = 1'b0; in_valid = 1'b0;
    in_data = '0; in_fm_clk = FM_CLK_DATA; cell_div = 8'd1;
    #23;
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_strobe", 16'(cell_strobe), 16'h0);
    chk("rst_flux", 16'(flux_out), 16'h0);
    chk("rst_underrun", 16'(underrun), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    enable = 1'b1; exp_period = 1;
    send(8'h00, 1'b0, MODE_MFM, FM_CLK_DATA, 16'hAAAA);
    send(8'h01, 1'b0, MODE_MFM, FM_CLK_DATA, 16'hAAA9);
    end_stream();

    send(8'hA1, 1'b1, MODE_MFM, FM_CLK_DATA, 16'h4489);
    send(8'h00, 1'b0, MODE_MFM, FM_CLK_DATA, 16'h2AAA);
    end_stream();

    send(8'hFE, 1'b1, MODE_FM, 8'hC7, 16'hF57E);
    send(8'h00, 1'b0, MODE_FM, FM_CLK_DATA, 16'hAAAA);
    end_stream();

    cell_div = 8'd4; exp_period = 4;
    send(8'hFF, 1'b0, MODE_MFM, FM_CLK_DATA, 16'h5555);
    end_stream();

    cell_div = 8'd2; exp_period = 2;
    base = nstrobe;
    send(8'h00, 1'b0, MODE_MFM, FM_CLK_DATA, 16'hAAAA);
    n = 0;
    while (nstrobe < base + 7 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_cell7", 16'(nstrobe >= base + 7), 16'h1);
    reset = 1'b1;
    #1;
    chk("midrst_strobe", 16'(cell_strobe), 16'h0);
    chk("midrst_flux", 16'(flux_out), 16'h0);
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_underrun", 16'(underrun), 16'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("postrst_busy", 16'(busy), 16'h0);
    chk("postrst_in_ready", 16'(in_ready), 16'h1);

    cell_div = 8'd0; exp_period = 1;
    send(8'h00, 1'b0, MODE_MFM, FM_CLK_DATA, 16'hAAAA);
    send(8'h01, 1'b0, MODE_MFM, FM_CLK_DATA, 16'hAAA9);
    end_stream();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
